// File: rtl/hazard_pkg.sv
// Shared constants and tag layout for the hazard scoreboard.
// Forward-select encodings match the ForwardE mux in the datapath.
package hazard_pkg;

  localparam int HZ_ADDR_W = 4;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_RESULTW = 2'b01;
  localparam logic [1:0] FWD_ALUOUTM = 2'b10;

  typedef struct packed {
    logic [HZ_ADDR_W-1:0] addr;
    logic                 regwrite;
    logic                 memtoreg;
    logic                 pcsrc;
  } hz_tag_t;

endpackage

// File: rtl/hazard_tag_stage.sv
// One pipeline tag register: async reset, synchronous clear (bubble) and load enable.
module hazard_tag_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // Clear beats enable so a flushed stage always becomes a bubble.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding controller with its own E/M/W destination-tag pipeline.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W = HZ_ADDR_W,
  parameter int NSRC   = 2,
  parameter int PC_REG = 15,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC*ADDR_W-1:0] RASrcD,
  input  logic [NSRC-1:0]        SrcUsedD,
  input  logic [ADDR_W-1:0]      WA3D,
  input  logic                   RegWriteD,
  input  logic                   MemtoRegD,
  input  logic                   PCSrcD,
  input  logic                   CondExE,
  input  logic                   BranchTakenE,
  output logic [2*NSRC-1:0]      ForwardE,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic [CNT_W-1:0]       StallCnt,
  output logic [CNT_W-1:0]       FlushCnt
);

  localparam int EW = NSRC*ADDR_W + NSRC + ADDR_W + 3;
  localparam int MW = ADDR_W + 3;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_REG);

  logic [EW-1:0] e_d, e_q;
  logic [MW-1:0] m_d, m_q, w_q;

  logic [NSRC*ADDR_W-1:0] ra_src_e;
  logic [NSRC-1:0]        src_used_e;
  logic [ADDR_W-1:0]      wa3_e, wa3_m, wa3_w;
  logic                   reg_write_e, mem_to_reg_e, pc_src_e;
  logic                   reg_write_m, pc_src_m;
  logic                   reg_write_w, pc_src_w;
  logic                   unused_memtoreg_w;

  logic [NSRC-1:0] hit_m, hit_w, ld_hit;
  logic            ldr_stall, pc_wr_pend;

  assign e_d = {RASrcD, SrcUsedD, WA3D, RegWriteD, MemtoRegD, PCSrcD};
  assign m_d = {wa3_e, reg_write_e & CondExE, mem_to_reg_e, pc_src_e & CondExE};

  hazard_tag_stage #(.W(EW)) u_stage_e (
    .clk(clk), .reset(reset), .clr_i(FlushE), .en_i(1'b1), .d_i(e_d), .q_o(e_q)
  );

  hazard_tag_stage #(.W(MW)) u_stage_m (
    .clk(clk), .reset(reset), .clr_i(1'b0), .en_i(1'b1), .d_i(m_d), .q_o(m_q)
  );

  hazard_tag_stage #(.W(MW)) u_stage_w (
    .clk(clk), .reset(reset), .clr_i(1'b0), .en_i(1'b1), .d_i(m_q), .q_o(w_q)
  );

  assign {ra_src_e, src_used_e, wa3_e, reg_write_e, mem_to_reg_e, pc_src_e} = e_q;
  assign wa3_m       = m_q[MW-1 -: ADDR_W];
  assign reg_write_m = m_q[2];
  assign pc_src_m    = m_q[0];
  assign wa3_w       = w_q[MW-1 -: ADDR_W];
  assign reg_write_w = w_q[2];
  assign pc_src_w    = w_q[0];
  // Load flag only matters while the producer sits in E.
  assign unused_memtoreg_w = w_q[1];

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      logic [ADDR_W-1:0] ra_e;
      logic [ADDR_W-1:0] ra_d;

      assign ra_e = ra_src_e[gi*ADDR_W +: ADDR_W];
      assign ra_d = RASrcD[gi*ADDR_W +: ADDR_W];

      assign hit_m[gi]  = src_used_e[gi] && reg_write_m && (wa3_m == ra_e) && (ra_e != PC_A);
      assign hit_w[gi]  = src_used_e[gi] && reg_write_w && (wa3_w == ra_e) && (ra_e != PC_A);
      assign ld_hit[gi] = SrcUsedD[gi] && (ra_d == wa3_e) && (ra_d != PC_A);

      // The younger M result takes priority over W.
      assign ForwardE[2*gi +: 2] = hit_m[gi] ? FWD_ALUOUTM :
                                   hit_w[gi] ? FWD_RESULTW : FWD_REG;
    end
  endgenerate

  assign ldr_stall  = mem_to_reg_e & reg_write_e & (|ld_hit);
  assign pc_wr_pend = PCSrcD | pc_src_e | pc_src_m;

  assign StallF = ldr_stall | pc_wr_pend;
  assign StallD = ldr_stall;
  assign FlushD = pc_wr_pend | pc_src_w | BranchTakenE;
  assign FlushE = ldr_stall | BranchTakenE;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating: a wrapped counter would silently under-report long runs.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((FlushD | FlushE) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: directed pipeline scenarios plus
// randomized traffic against an instruction-level pipeline model (HAZARD_PERF_CNT_EN aware).
module tb_hazard_scoreboard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  RASrcD;
  logic [1:0]  SrcUsedD;
  logic [3:0]  WA3D;
  logic        RegWriteD, MemtoRegD, PCSrcD, CondExE, BranchTakenE;
  logic [3:0]  ForwardE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [31:0] StallCnt, FlushCnt;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.ADDR_W(4), .NSRC(2), .PC_REG(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .RASrcD(RASrcD), .SrcUsedD(SrcUsedD), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE),
    .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  // Instruction record as it travels down the pipe: index 0=E, 1=M, 2=W.
  typedef struct packed {
    logic [7:0] src;
    logic [1:0] used;
    logic [3:0] dst;
    logic       rw;
    logic       ld;
    logic       pc;
  } instr_t;

  instr_t      pipe [3];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [3:0]  exp_fwd;
  logic        exp_sf, exp_sd, exp_fd, exp_fe;
  logic [31:0] exp_scnt, exp_fcnt;

  function automatic logic [7:0] outs();
    return {ForwardE, StallF, StallD, FlushD, FlushE};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    exp_scnt = '0;
    exp_fcnt = '0;
  endfunction

  // Outputs as the hazard rules dictate for the current pipe contents and D inputs.
  function automatic void model_eval();
    logic [3:0] s;
    logic [3:0] d;
    logic       ldr;
    logic       pend;
    exp_fwd = '0;
    ldr     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = pipe[0].src[i*4 +: 4];
      if (pipe[0].used[i] && s != 4'd15) begin
        if (pipe[1].rw && pipe[1].dst == s)      exp_fwd[2*i +: 2] = 2'b10;
        else if (pipe[2].rw && pipe[2].dst == s) exp_fwd[2*i +: 2] = 2'b01;
      end
      d = RASrcD[i*4 +: 4];
      if (SrcUsedD[i] && d != 4'd15 && d == pipe[0].dst && pipe[0].ld && pipe[0].rw) ldr = 1'b1;
    end
    pend   = PCSrcD | pipe[0].pc | pipe[1].pc;
    exp_sf = ldr | pend;
    exp_sd = ldr;
    exp_fd = pend | pipe[2].pc | BranchTakenE;
    exp_fe = ldr | BranchTakenE;
  endfunction

  task automatic drive(input logic [7:0] src, input logic [1:0] used, input logic [3:0] wa,
                       input logic rw, input logic ld, input logic pc, input logic cond, input logic bt);
    RASrcD = src; SrcUsedD = used; WA3D = wa;
    RegWriteD = rw; MemtoRegD = ld; PCSrcD = pc;
    CondExE = cond; BranchTakenE = bt;
    $display("[%0t] drive src=%h used=%b wa=%0d rw=%b ld=%b pc=%b cond=%b bt=%b",
             $time, src, used, wa, rw, ld, pc, cond, bt);
  endtask

  // Advance one clock for both the DUT and the model.
  task automatic tick();
    instr_t nxt;
    model_eval();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      exp_scnt = exp_scnt + 32'(exp_sd);
      exp_fcnt = exp_fcnt + 32'(exp_fd | exp_fe);
      nxt = '{src: RASrcD, used: SrcUsedD, dst: WA3D, rw: RegWriteD, ld: MemtoRegD, pc: PCSrcD};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[1].rw = pipe[1].rw & CondExE;
      pipe[1].pc = pipe[1].pc & CondExE;
      pipe[0] = exp_fe ? '0 : nxt;
    end
    #1;
  endtask

  task automatic nop(input int n);
    repeat (n) begin
      drive(8'h00, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive(8'h00, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (outs() !== 8'h00) begin
      err_cnt++; $display("FAIL reset_outs: got %b want %b", outs(), 8'h00);
    end
    vec_cnt++;
    if ({StallCnt, FlushCnt} !== 64'd0) begin
      err_cnt++; $display("FAIL reset_cnt: got %h/%h want 0/0", StallCnt, FlushCnt);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fwd_alu();
    nop(2);
    drive(8'h00, 2'b00, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);  // ADD r1
    #1; tick();
    drive({4'd3, 4'd1}, 2'b11, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);  // SUB r2,r1,r3
    #1;
    vec_cnt++;
    if (outs() !== 8'h00) begin
      err_cnt++; $display("FAIL alu_d_cycle: got %b want %b", outs(), 8'h00);
    end
    tick();
    drive({4'd8, 4'd1}, 2'b11, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);  // dependent on r1
    #1;
    vec_cnt++;
    if (outs() !== 8'b0010_0000) begin
      err_cnt++; $display("FAIL alu_fwd_m: got %b want %b", outs(), 8'b0010_0000);
    end
    tick();
    drive(8'h00, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    vec_cnt++;
    if (outs() !== 8'b0001_0000) begin
      err_cnt++; $display("FAIL alu_fwd_w: got %b want %b", outs(), 8'b0001_0000);
    end
    tick();
  endtask

  task automatic test_load_use();
    nop(2);
    drive(8'h00, 2'b00, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);  // LDR r4
    #1; tick();
    drive({4'd6, 4'd4}, 2'b11, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);  // ADD r5,r4,r6
    #1;
    vec_cnt++;
    if (outs() !== 8'b0000_1101) begin
      err_cnt++; $display("FAIL ldr_stall: got %b want %b", outs(), 8'b0000_1101);
    end
    tick();
    drive({4'd6, 4'd4}, 2'b11, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);  // held ADD
    #1;
    vec_cnt++;
    if (outs() !== 8'h00) begin
      err_cnt++; $display("FAIL ldr_bubble: got %b want %b", outs(), 8'h00);
    end
    tick();
    drive(8'h00, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    vec_cnt++;
    if (outs() !== 8'b0001_0000) begin
      err_cnt++; $display("FAIL ldr_fwd_w: got %b want %b", outs(), 8'b0001_0000);
    end
    tick();
    nop(1);
    vec_cnt++;
    if (outs() !== 8'h00) begin
      err_cnt++; $display("FAIL ldr_no_restall: got %b want %b", outs(), 8'h00);
    end
  endtask

  task automatic test_unused_src();
    nop(2);
    drive(8'h00, 2'b00, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);  // LDR r4
    #1; tick();
    drive({4'd4, 4'd4}, 2'b00, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    vec_cnt++;
    if (outs() !== 8'h00) begin
      err_cnt++; $display("FAIL unused_no_stall: got %b want %b", outs(), 8'h00);
    end
    tick();
    drive(8'h00, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    vec_cnt++;
    if (outs() !== 8'h00) begin
      err_cnt++; $display("FAIL unused_no_fwd: got %b want %b", outs(), 8'h00);
    end
    tick();
  endtask

  task automatic test_pc_reg();
    nop(2);
    drive(8'h00, 2'b00, 4'd15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);  // LDR r15 (no PC write flag)
    #1; tick();
    drive({4'd0, 4'd15}, 2'b01, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    vec_cnt++;
    if (outs() !== 8'h00) begin
      err_cnt++; $display("FAIL pcreg_no_stall: got %b want %b", outs(), 8'h00);
    end
    tick();
    drive(8'h00, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    vec_cnt++;
    if (outs() !== 8'h00) begin
      err_cnt++; $display("FAIL pcreg_no_fwd: got %b want %b", outs(), 8'h00);
    end
    tick();
  endtask

  task automatic test_pc_write();
    logic [7:0] want;
    for (int pass = 0; pass < 2; pass++) begin
      nop(3);
      for (int c = 0; c < 5; c++) begin
        if (c == 0) drive(8'h00, 2'b00, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        else        drive(8'h00, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, (pass == 1 && c == 1) ? 1'b0 : 1'b1, 1'b0);
        #1;
        if (pass == 0) want = {4'b0000, (c < 3), 1'b0, (c < 4), 1'b0};
        else           want = {4'b0000, (c < 2), 1'b0, (c < 2), 1'b0};
        vec_cnt++;
        if (outs() !== want) begin
          err_cnt++; $display("FAIL pcwrite_p%0d_c%0d: got %b want %b", pass, c, outs(), want);
        end
        tick();
      end
    end
  endtask

  task automatic test_branch_ldr_reset();
    nop(2);
    drive(8'h00, 2'b00, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);  // LDR r4
    #1; tick();
    drive({4'd6, 4'd4}, 2'b11, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    vec_cnt++;
    if (outs() !== 8'b0000_1111) begin
      err_cnt++; $display("FAIL branch_ldr: got %b want %b", outs(), 8'b0000_1111);
    end
    reset = 1'b1;
    #1;
    drive(8'h00, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    model_reset();
    vec_cnt++;
    if (outs() !== 8'h00) begin
      err_cnt++; $display("FAIL midreset_outs: got %b want %b", outs(), 8'h00);
    end
    vec_cnt++;
    if ({StallCnt, FlushCnt} !== 64'd0) begin
      err_cnt++; $display("FAIL midreset_cnt: got %h/%h want 0/0", StallCnt, FlushCnt);
    end
    reset = 1'b0;
    tick();
  endtask

  function automatic logic [3:0] rnd_reg();
    int r;
    r = $urandom_range(0, 9);
    return (r > 7) ? 4'd15 : 4'(r);
  endfunction

  task automatic test_random();
    logic [63:0] want_cnt;
    for (int n = 0; n < 200; n++) begin
      drive({rnd_reg(), rnd_reg()}, 2'($urandom_range(0, 3)), rnd_reg(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 9) == 0));
      #1;
      model_eval();
      vec_cnt++;
      if (outs() !== {exp_fwd, exp_sf, exp_sd, exp_fd, exp_fe}) begin
        err_cnt++;
        $display("FAIL random_%0d: got %b want %b", n, outs(), {exp_fwd, exp_sf, exp_sd, exp_fd, exp_fe});
      end
`ifdef HAZARD_PERF_CNT_EN
      want_cnt = {exp_scnt, exp_fcnt};
`else
      want_cnt = 64'd0;
`endif
      vec_cnt++;
      if ({StallCnt, FlushCnt} !== want_cnt) begin
        err_cnt++;
        $display("FAIL random_cnt_%0d: got %h want %h", n, {StallCnt, FlushCnt}, want_cnt);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_unused_src();
    test_pc_reg();
    test_pc_write();
    test_branch_ldr_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
